// File: rtl/sd_digit_otf_reader_pkg.sv
// Shared digit codes, FSM states and digit decoder
// for the signed-digit quotient reader.
package sd_digit_pkg;

  localparam logic [1:0] SD_ZERO    = 2'b00;
  localparam logic [1:0] SD_POS     = 2'b01;
  localparam logic [1:0] SD_NEG     = 2'b11;
  localparam logic [1:0] SD_ILLEGAL = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD
  } state_t;

  typedef struct packed {
    logic pos;
    logic neg;
    logic illegal;
  } sd_dec_t;

  function automatic sd_dec_t sd_decode(
    input logic [1:0] code
  );
    sd_dec_t d;
    d = '0;
    unique case (1'b1)
      (code == SD_ZERO):    d = '0;
      (code == SD_POS):     d.pos = 1'b1;
      (code == SD_NEG):     d.neg = 1'b1;
      (code == SD_ILLEGAL): d.illegal = 1'b1;
      default:              d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sd_digit_otf_reader_if.sv
// Start / RAM read / result handshake bundle
// of the signed-digit quotient reader.
interface sd_digit_otf_reader_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_DIGITS = 32
);
  localparam int RES_WIDTH = NUM_DIGITS + 1;

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [1:0]            ram_q;
  logic                  busy;
  logic [RES_WIDTH-1:0]  result;
  logic                  result_valid;
  logic                  result_ready;
  logic                  digit_err;

  modport master (
    input  start,
    input  base_addr,
    input  ram_q,
    input  result_ready,
    output ram_read_addr,
    output busy,
    output result,
    output result_valid,
    output digit_err
  );

  modport slave (
    output start,
    output base_addr,
    output ram_q,
    output result_ready,
    input  ram_read_addr,
    input  busy,
    input  result,
    input  result_valid,
    input  digit_err
  );

endinterface

// File: rtl/sd_digit_otf_reader_converter.sv
// On-the-fly Q/QM conversion of a signed-digit
// stream into a two's-complement fraction.
module sd_otf_converter
  import sd_digit_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         shift_en,
  input  logic [1:0]   digit,
  output logic [W-1:0] q
);

  // QM is always Q minus one ulp; its top bit
  // never reaches Q, so only W-1 bits are kept.
  logic [W-1:0] q_r;
  logic [W-2:0] qm_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r  <= '0;
      qm_r <= '1;
    end else if (init) begin
      q_r  <= '0;
      qm_r <= '1;
    end else if (shift_en) begin
      unique case (digit)
        SD_POS: begin
          q_r  <= W'({q_r, 1'b1});
          qm_r <= (W-1)'({q_r, 1'b0});
        end
        SD_NEG: begin
          q_r  <= {qm_r, 1'b1};
          qm_r <= (W-1)'({qm_r, 1'b0});
        end
        default: begin
          q_r  <= W'({q_r, 1'b0});
          qm_r <= (W-1)'({qm_r, 1'b1});
        end
      endcase
    end
  end

  assign q = q_r;

endmodule

// File: rtl/sd_digit_otf_reader.sv
// Reads NUM_DIGITS signed digits from the quotient
// RAM and returns the converted value on a handshake.
module sd_digit_otf_reader
  import sd_digit_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_DIGITS = 32
) (
  input  logic clk,
  input  logic rst_n,
  sd_digit_otf_reader_if.master bus
);

  localparam int RES_WIDTH = NUM_DIGITS + 1;
  localparam int CW = $clog2(NUM_DIGITS + 2);
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS);
  localparam logic [CW-1:0] LAST_ADDR = CW'(NUM_DIGITS - 1);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  busy_q;
  logic                  busy_d;
  logic                  valid_q;
  logic                  valid_d;
  logic                  err_q;
  logic                  err_d;
  logic                  init;
  logic                  shift_en;
  sd_dec_t               dec;
  logic [1:0]            digit;
  logic [RES_WIDTH-1:0]  q;

  assign dec = sd_decode(bus.ram_q);
  // An illegal code collapses to a zero digit.
  assign digit = {dec.neg, dec.pos | dec.neg};

  sd_otf_converter #(
    .W (RES_WIDTH)
  ) u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (init),
    .shift_en (shift_en),
    .digit    (digit),
    .q        (q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // cnt counts READ edges; the first one only
  // covers the RAM latency and consumes nothing.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    err_d    = err_q;
    init     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          addr_d  = bus.base_addr;
          cnt_d   = '0;
          init    = 1'b1;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q < LAST_ADDR) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
        if (cnt_q != '0) begin
          shift_en = 1'b1;
          if (dec.illegal) begin
            err_d = 1'b1;
          end
        end
        if (cnt_q == LAST) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.result_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ram_read_addr = addr_q;
  assign bus.busy          = busy_q;
  assign bus.result        = q;
  assign bus.result_valid  = valid_q;
  assign bus.digit_err     = err_q;

endmodule
